// File: rtl/axis_burst_gen_pkg.sv
// axis_burst_gen_pkg -- shared types and helpers for the parallel AXI-stream burst source.
// Rev 1.0
`default_nettype none

package axis_burst_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND   = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   localparam logic [31:0] C_LFSR16_TAPS = 32'h0000_B400;

   // Galois feedback masks for maximal-length sequences at common widths.
   function automatic logic [31:0] lfsr_taps(input int unsigned width);
      case (width)
         8:       return 32'h0000_00B8;
         16:      return C_LFSR16_TAPS;
         24:      return 32'h00E1_0000;
         32:      return 32'h8020_0003;
         default: return C_LFSR16_TAPS;
      endcase
   endfunction

   // Channel number in the upper half, sample index in the lower half.
   function automatic logic [63:0] data_tag(input logic [31:0] ch,
                                            input logic [63:0] idx,
                                            input int unsigned dwidth);
      logic [63:0] mask;
      mask = (64'd1 << (dwidth / 2)) - 64'd1;
      return ({32'd0, ch} << (dwidth / 2)) | (idx & mask);
   endfunction

endpackage

`default_nettype wire

// File: rtl/axis_parallel_burst_gen_lfsr_gen.sv
// lfsr_gen -- right-shifting Galois LFSR with synchronous reload and step enable.
// Rev 1.0
`default_nettype none

module lfsr_gen #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] SEED  = 'h1,
   parameter logic [WIDTH-1:0] TAPS  = 'h1
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             en_i,
   input  logic             reload_i,
   output logic [WIDTH-1:0] out_o
);

   logic [WIDTH-1:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (reload_i) begin
         lfsr_d = SEED;
      end else if (en_i) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign out_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/axis_parallel_burst_gen.sv
// axis_parallel_burst_gen -- multi-channel AXI-stream ramp burst source.
// Rev 1.0
`default_nettype none

module axis_parallel_burst_gen
   import axis_burst_gen_pkg::*;
#(
   parameter int                    DWIDTH      = 32,
   parameter int                    CHANNELS    = 2,
   parameter int                    COUNT_WIDTH = 16,
   parameter int                    LFSR_WIDTH  = 16,
   parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         start_i,
   input  logic                         abort_i,
   input  logic [COUNT_WIDTH-1:0]       n_samples_i,
   input  logic                         rand_arrivals_i,
   input  logic                         ignore_ready_i,
   output logic [CHANNELS*DWIDTH-1:0]   data_o,
   output logic [CHANNELS-1:0]          valid_o,
   input  logic [CHANNELS-1:0]          ready_i,
   output logic [CHANNELS-1:0]          last_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         aborted_o,
   output logic [CHANNELS-1:0]          ch_done_o
);

   localparam logic [LFSR_WIDTH-1:0] C_TAPS = LFSR_WIDTH'(lfsr_taps(LFSR_WIDTH));

   state_e                  state_q, state_d;
   logic [COUNT_WIDTH-1:0]  n_samples_q, n_samples_d;
   logic                    rand_q, rand_d;
   logic                    ign_q, ign_d;
   logic                    zero_done_q, zero_done_d;
   logic                    aborted_q, aborted_d;
   logic [CHANNELS-1:0]     ch_done_d;
   logic [LFSR_WIDTH-1:0]   lfsr;
   logic                    start_go;
   logic                    sending;

   assign start_go = (state_q == ST_IDLE) && start_i;
   assign sending  = (state_q == ST_SEND);

   lfsr_gen #(
      .WIDTH (LFSR_WIDTH),
      .SEED  (LFSR_SEED),
      .TAPS  (C_TAPS)
   ) u_lfsr (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (sending),
      .reload_i  (start_go),
      .out_o     (lfsr)
   );

   if (CHANNELS < LFSR_WIDTH) begin : g_lfsr_spare
      logic lfsr_spare_unused;
      assign lfsr_spare_unused = ^lfsr[LFSR_WIDTH-1:CHANNELS];
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_i && (n_samples_i != '0)) state_d = ST_SEND;
         ST_SEND: begin
            if (abort_i)           state_d = ST_IDLE;
            else if (&ch_done_d)   state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o    = (state_q == ST_SEND);
      done_o    = (state_q == ST_FINISH) || zero_done_q;
      aborted_o = aborted_q;
   end

   // ---------------- burst configuration ----------------
   always_comb begin
      n_samples_d = n_samples_q;
      rand_d      = rand_q;
      ign_d       = ign_q;
      if (start_go) begin
         n_samples_d = n_samples_i;
         rand_d      = rand_arrivals_i;
         ign_d       = ignore_ready_i;
      end
      zero_done_d = start_go && (n_samples_i == '0);
      aborted_d   = sending && abort_i;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         n_samples_q <= '0;
         rand_q      <= 1'b0;
         ign_q       <= 1'b0;
         zero_done_q <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         n_samples_q <= n_samples_d;
         rand_q      <= rand_d;
         ign_q       <= ign_d;
         zero_done_q <= zero_done_d;
         aborted_q   <= aborted_d;
      end
   end

   // ---------------- per-channel beat generation ----------------
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [COUNT_WIDTH-1:0] idx_q, idx_d;
      logic [DWIDTH-1:0]      data_q, data_d;
      logic                   valid_q, valid_d;
      logic                   last_q, last_d;
      logic                   done_q, done_d;
      logic                   xfer;

      always_comb begin
         xfer    = valid_q && (ready_i[i] || ign_q);
         idx_d   = idx_q;
         data_d  = data_q;
         valid_d = valid_q;
         last_d  = last_q;
         done_d  = done_q;
         if (start_go) begin
            idx_d  = '0;
            done_d = 1'b0;
         end else if (sending) begin
            if (xfer) begin
               if (last_q) done_d = 1'b1;
               else        idx_d  = idx_q + COUNT_WIDTH'(1);
               valid_d = 1'b0;
               last_d  = 1'b0;
            end
            // A new beat is only launched into an empty slot, so the LFSR never withdraws one.
            if (!valid_d && !done_d && (!rand_q || lfsr[i]) && !abort_i) begin
               valid_d = 1'b1;
               last_d  = (idx_d == n_samples_q - COUNT_WIDTH'(1));
               data_d  = DWIDTH'(data_tag(32'(i), 64'(idx_d), DWIDTH));
            end
            if (abort_i) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
            end
         end
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
         end
      end

      assign ch_done_d[i]                 = done_d;
      assign ch_done_o[i]                 = done_q;
      assign valid_o[i]                   = valid_q;
      assign last_o[i]                    = last_q;
      assign data_o[i*DWIDTH +: DWIDTH]   = data_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_axis_parallel_burst_gen.sv
// tb_axis_parallel_burst_gen -- scoreboard bench for the parallel burst source.
// Rev 1.0
`default_nettype none

module tb_axis_parallel_burst_gen;

   localparam int DW = 32;
   localparam int CH = 2;
   localparam int CW = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start, abort, rand_arrivals, ignore_ready;
   logic [CW-1:0]    n_samples;
   logic [CH*DW-1:0] data;
   logic [CH-1:0]    valid, ready, last, ch_done;
   logic             busy, done, aborted;

   int               n_chk = 0;
   int               n_err = 0;
   int               done_cnt = 0;
   int               beats [CH];
   logic [32:0]      exp_q [CH][$];
   logic             pend [CH];
   logic [32:0]      pend_val [CH];
   logic             tb_ign = 1'b0;
   logic             rnd_ready = 1'b0;

   always #5 clk = ~clk;

   axis_parallel_burst_gen #(
      .DWIDTH      (DW),
      .CHANNELS    (CH),
      .COUNT_WIDTH (CW),
      .LFSR_WIDTH  (16),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .clk_i           (clk),
      .reset_n_i       (reset_n),
      .start_i         (start),
      .abort_i         (abort),
      .n_samples_i     (n_samples),
      .rand_arrivals_i (rand_arrivals),
      .ignore_ready_i  (ignore_ready),
      .data_o          (data),
      .valid_o         (valid),
      .ready_i         (ready),
      .last_o          (last),
      .busy_o          (busy),
      .done_o          (done),
      .aborted_o       (aborted),
      .ch_done_o       (ch_done)
   );

   task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: beats that will be accepted on the coming edge are popped against the scoreboard.
   always @(negedge clk) begin
      if (done) done_cnt++;
      for (int c = 0; c < CH; c++) begin
         logic        v, x;
         logic [32:0] obs;
         v   = valid[c];
         x   = v && (ready[c] || tb_ign);
         obs = {last[c], data[c*DW +: DW]};
         if (pend[c] && reset_n) begin
            tb_check("hold_valid", 64'(v), 64'd1);
            tb_check("hold_beat", 64'(obs), 64'(pend_val[c]));
         end
         if (x && reset_n) begin
            if (exp_q[c].size() == 0) begin
               tb_check("sb_underflow", 64'(exp_q[c].size()), 64'd1);
            end else begin
               tb_check("beat", 64'(obs), 64'(exp_q[c].pop_front()));
               beats[c]++;
            end
         end
         pend[c]     = v && !x && reset_n && !abort;
         pend_val[c] = obs;
      end
   end

   always @(posedge clk) begin
      if (rnd_ready) begin
         #1;
         ready = 2'($urandom);
      end
   end

   task automatic clear_sb();
      for (int c = 0; c < CH; c++) begin
         exp_q[c].delete();
         beats[c] = 0;
         pend[c]  = 1'b0;
      end
   endtask

   task automatic do_start(input int n, input logic rnd, input logic ign);
      @(posedge clk); #1;
      clear_sb();
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < n; k++) begin
            logic [32:0] e;
            e[32]   = (k == n - 1);
            e[31:0] = 32'((c << 16) | k);
            exp_q[c].push_back(e);
         end
      end
      tb_ign        = ign;
      n_samples     = CW'(n);
      rand_arrivals = rnd;
      ignore_ready  = ign;
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      logic found;
      found = 1'b0;
      cyc   = 0;
      while (!found && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (done) found = 1'b1;
      end
      if (!found) tb_check("done_timeout", 64'(done), 64'd1);
   endtask

   task automatic check_sb_empty(input string tag);
      for (int c = 0; c < CH; c++) tb_check(tag, 64'(exp_q[c].size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int dc;
      for (int c = 0; c < CH; c++) begin
         pend[c]  = 1'b0;
         beats[c] = 0;
      end
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; rand_arrivals = 1'b0;
      ignore_ready = 1'b0; n_samples = '0; ready = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tb_check("rst_valid", 64'(valid), 64'd0);
      tb_check("rst_last", 64'(last), 64'd0);
      tb_check("rst_data", 64'(data), 64'd0);
      tb_check("rst_busy", 64'(busy), 64'd0);
      tb_check("rst_done", 64'(done), 64'd0);
      tb_check("rst_aborted", 64'(aborted), 64'd0);
      tb_check("rst_ch_done", 64'(ch_done), 64'd0);
      reset_n = 1'b1;

      // Basic burst with latency and done timing.
      ready = 2'b11;
      do_start(4, 1'b0, 1'b0);
      @(negedge clk);
      tb_check("t1_busy", 64'(busy), 64'd1);
      tb_check("t1_valid_lat1", 64'(valid), 64'd0);
      @(negedge clk);
      tb_check("t1_valid_lat2", 64'(valid), 64'd3);
      wait_done(20, cyc);
      tb_check("t1_done_cycle", 64'(cyc), 64'd4);
      tb_check("t1_ch_done", 64'(ch_done), 64'd3);
      tb_check("t1_busy_fin", 64'(busy), 64'd0);
      check_sb_empty("t1_sb_left");
      @(negedge clk);
      tb_check("t1_done_pulse", 64'(done), 64'd0);

      // Channel 1 stalled; channel 0 finishes alone.
      @(posedge clk); #1;
      ready = 2'b01;
      dc    = done_cnt;
      do_start(3, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      tb_check("t2_ch_done_part", 64'(ch_done), 64'd1);
      tb_check("t2_valid1_held", 64'(valid[1]), 64'd1);
      tb_check("t2_data1_held", 64'(data[DW +: DW]), 64'h0001_0000);
      tb_check("t2_no_done", 64'(done_cnt), 64'(dc));
      @(posedge clk); #1;
      ready = 2'b11;
      wait_done(20, cyc);
      tb_check("t2_ch_done", 64'(ch_done), 64'd3);
      check_sb_empty("t2_sb_left");

      // Random arrivals with random ready.
      rnd_ready = 1'b1;
      do_start(100, 1'b1, 1'b0);
      wait_done(5000, cyc);
      rnd_ready = 1'b0;
      @(posedge clk); #2;
      ready = 2'b11;
      tb_check("t3_beats0", 64'(beats[0]), 64'd100);
      tb_check("t3_beats1", 64'(beats[1]), 64'd100);
      check_sb_empty("t3_sb_left");

      // Ready ignored.
      ready = 2'b00;
      do_start(5, 1'b0, 1'b1);
      wait_done(20, cyc);
      tb_check("t4_done_cycle", 64'(cyc), 64'd7);
      tb_check("t4_beats0", 64'(beats[0]), 64'd5);
      tb_check("t4_beats1", 64'(beats[1]), 64'd5);
      ready = 2'b11;

      // Zero-length burst.
      do_start(0, 1'b0, 1'b0);
      @(negedge clk);
      tb_check("t5_zero_done", 64'(done), 64'd1);
      tb_check("t5_zero_busy", 64'(busy), 64'd0);
      tb_check("t5_zero_valid", 64'(valid), 64'd0);
      @(negedge clk);
      tb_check("t5_zero_done_pulse", 64'(done), 64'd0);
      tb_check("t5_zero_valid2", 64'(valid), 64'd0);

      // Abort partway through.
      do_start(8, 1'b0, 1'b0);
      cyc = 0;
      while (beats[0] < 2 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      tb_check("t6_reach_beat2", 64'(beats[0] >= 2), 64'd1);
      dc = done_cnt;
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      tb_check("t6_abort_valid", 64'(valid), 64'd0);
      tb_check("t6_abort_last", 64'(last), 64'd0);
      tb_check("t6_aborted", 64'(aborted), 64'd1);
      tb_check("t6_abort_busy", 64'(busy), 64'd0);
      tb_check("t6_abort_ch_done", 64'(ch_done), 64'd0);
      @(negedge clk);
      tb_check("t6_aborted_pulse", 64'(aborted), 64'd0);
      tb_check("t6_no_done", 64'(done_cnt), 64'(dc));
      clear_sb();

      // Asynchronous reset mid-burst, then a clean burst.
      do_start(20, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      #2;
      reset_n = 1'b0;
      for (int c = 0; c < CH; c++) pend[c] = 1'b0;
      #1;
      tb_check("t7_rst_valid", 64'(valid), 64'd0);
      tb_check("t7_rst_data", 64'(data), 64'd0);
      tb_check("t7_rst_busy", 64'(busy), 64'd0);
      tb_check("t7_rst_last", 64'(last), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      clear_sb();
      do_start(4, 1'b0, 1'b0);
      wait_done(20, cyc);
      tb_check("t7_done_cycle", 64'(cyc), 64'd6);
      tb_check("t7_beats0", 64'(beats[0]), 64'd4);
      check_sb_empty("t7_sb_left");

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axis_parallel_burst_gen.md
Name: axis_parallel_burst_gen

Overview:
- Synthesizable multi-channel AXI-stream burst source: on `start`, every one of CHANNELS parallel streams emits exactly `n_samples` beats of deterministic ramp data, with `last` on the final beat of each channel.
- Modes: random arrivals (LFSR-gated valid), ready-ignoring realtime mode, abort.
- Used as on-chip stimulus for DAC/DMA paths and as a hardware replacement for testbench-driven parallel sample sending.

Parameters:
- DWIDTH, 32: per-channel data width; must be >= 16.
- CHANNELS, 2: number of parallel streams, 1..LFSR_WIDTH.
- COUNT_WIDTH, 16: width of the sample counter and `n_samples`.
- LFSR_WIDTH, 16: Galois LFSR width for random-arrival gating.
- LFSR_SEED, 16'hACE1: LFSR reload value; must be nonzero.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a burst when idle
- abort  in  1  one-cycle pulse; terminates a burst in progress
- n_samples  in  COUNT_WIDTH  beats per channel; latched at start
- rand_arrivals  in  1  gate valid with LFSR bits; latched at start
- ignore_ready  in  1  treat every valid beat as accepted; latched at start
- data  out  CHANNELS*DWIDTH  channel i occupies bits [i*DWIDTH +: DWIDTH]
- valid  out  CHANNELS  per-channel valid
- ready  in  CHANNELS  per-channel ready
- last  out  CHANNELS  per-channel last
- busy  out  1  high from the cycle after an accepted start until the burst ends
- done  out  1  one-cycle pulse when all channels have sent n_samples
- aborted  out  1  one-cycle pulse on abort completion
- ch_done  out  CHANNELS  per-channel completion mask; cleared at start

Behaviour:
- Reset (async assert, sync deassert externally): state IDLE. `valid`, `last`, `data`, `busy`, `done`, `aborted`, `ch_done` = 0; LFSR = LFSR_SEED; counters = 0.
- Beat accepted on channel i: `xfer[i] = valid[i] & (ready[i] | ignore_ready_q)`.
- States: IDLE, SEND, FINISH.
- IDLE, `start` with `n_samples` != 0:
  - latch config; clear counters and `ch_done`; reload LFSR; go to SEND.
  - `busy` high next cycle.
- IDLE, `start` with `n_samples` == 0: `done` pulses next cycle; stay IDLE; no beats.
- IDLE: `start` is ignored outside IDLE.
- Valid generation in SEND:
  - Channel i may raise `valid[i]` when `!ch_done[i]`, no beat is pending, and (`!rand_arrivals_q` or `lfsr[i]`).
  - Once raised, `valid[i]` holds with stable `data`/`last` until `xfer[i]`. The LFSR never drops a pending beat.
- Latency: non-random mode, `start` at cycle 0 → `valid` = all-ones at cycle 2 (cycle 1 enters SEND, registered outputs).
- Back-to-back: with `ready` = 1, one beat per channel per cycle; no bubbles.
- Data: `data[i] = (i << (DWIDTH/2)) | idx_i`, where `idx_i` is zero-extended to DWIDTH/2 bits (truncate if COUNT_WIDTH > DWIDTH/2).
- `last[i]` is high exactly on the beat where `idx_i == n_samples_q - 1`.
- On `xfer[i]`:
  - if last: set `ch_done[i]`; drop `valid[i]` next cycle unless a new beat is issued (none, since the channel is done).
  - else: `idx_i` increments.
- LFSR steps every cycle in SEND; gate bit for channel i is `lfsr[i]`.
- All `ch_done` set → FINISH for one cycle: `done` = 1, `busy` = 0 → IDLE.
- Channels finish independently; a stalled channel (`ready` = 0) does not stall the others.
- `abort` in SEND: all `valid`/`last` cleared next cycle (explicit protocol exception); `aborted` pulses; `done` does not pulse; → IDLE; `ch_done` retains its partial value.
- `abort` in IDLE or FINISH is ignored.
- `abort` and `start` in the same IDLE cycle: `start` wins.
- `reset_n` low mid-burst: immediate return to reset values.
- Counter width: `n_samples` up to 2^COUNT_WIDTH - 1; no wrap inside a burst.

Decomposition:
- Package `axis_burst_gen_pkg`: state enum (IDLE/SEND/FINISH), LFSR tap constant per LFSR_WIDTH, data-tag helper function.
- Sub-module `lfsr_gen` (WIDTH, SEED, TAPS; enable, reload, out), reusable elsewhere.
- Per-channel logic is a generate loop, not a separate module.

Test Plan:
- CHANNELS=2, n_samples=4, ready=2'b11, no modes → each channel emits idx 0..3 in 4 consecutive cycles; ch1 data = 0x0001_000k; `last` on idx 3; `done` one cycle later.
- ready[1] held 0 for 10 cycles, ready[0]=1, n_samples=3 → ch0 finishes in 3 cycles; ch1 holds `valid` with data 0x0001_0000 stable; `done` only after ch1's 3rd beat.
- rand_arrivals=1, random ready, n_samples=100 → exactly 100 beats per channel; valid never drops without xfer; idx sequence contiguous.
- ignore_ready=1, ready=0, n_samples=5 → 5 beats per channel in 5 cycles; done pulses.
- n_samples=0 start → done next cycle; valid stays 0. Abort at beat 2 of 8 → valid=0 next cycle, aborted=1, done=0, ch_done=0.
- reset_n pulsed low mid-burst → all outputs 0 asynchronously; subsequent start runs a clean burst from idx 0.
